// File: rtl/bcd_parity_range_counter_if.sv
// Control/status bundle for the parity-filtered BCD range counter.
// The master drives the controls and the slave (the counter) returns count/wrap/err.
interface bcd_parity_range_counter_if #(
  parameter int DIGITS = 1
);
  logic                  en;
  logic                  up;
  logic [1:0]            mode;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic                  err;

  modport master (
    output en, up, mode, load, load_val,
    input  count, wrap, err
  );

  modport slave (
    input  en, up, mode, load, load_val,
    output count, wrap, err
  );
endinterface

// File: rtl/bcd_parity_range_counter.sv
// Multi-digit BCD counter stepping through [MIN_VAL, MAX_VAL] filtered by parity mode.
// Stepping is computed on a binary copy of the count and converted back to BCD.
module bcd_parity_range_counter #(
  parameter int DIGITS  = 1,
  parameter int MIN_VAL = 4,
  parameter int MAX_VAL = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  bcd_parity_range_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;

  localparam logic [1:0] MODE_ALL  = 2'b00;
  localparam logic [1:0] MODE_ODD  = 2'b01;
  localparam logic [1:0] MODE_EVEN = 2'b10;

  localparam int LO_ODD  = (MIN_VAL % 2 == 1) ? MIN_VAL : MIN_VAL + 1;
  localparam int LO_EVEN = (MIN_VAL % 2 == 1) ? MIN_VAL + 1 : MIN_VAL;
  localparam int HI_ODD  = (MAX_VAL % 2 == 1) ? MAX_VAL : MAX_VAL - 1;
  localparam int HI_EVEN = (MAX_VAL % 2 == 1) ? MAX_VAL - 1 : MAX_VAL;

  function automatic int bcd2bin(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v = v * 10 + int'(b[i*4 +: 4]);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] bin2bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic parity_ok(input int v, input logic [1:0] m);
    logic is_odd;
    is_odd = ((v & 1) == 1);
    case (m)
      MODE_ODD:  return is_odd;
      MODE_EVEN: return !is_odd;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic int lo_of(input logic [1:0] m);
    case (m)
      MODE_ODD:  return LO_ODD;
      MODE_EVEN: return LO_EVEN;
      default:   return MIN_VAL;
    endcase
  endfunction

  function automatic int hi_of(input logic [1:0] m);
    case (m)
      MODE_ODD:  return HI_ODD;
      MODE_EVEN: return HI_EVEN;
      default:   return MAX_VAL;
    endcase
  endfunction

  logic [W-1:0]      count_q, count_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;

  logic [DIGITS-1:0] digit_ok;
  logic [1:0]        eff_mode;
  logic [W-1:0]      lo_bcd;
  logic              load_ok;
  int                lo_v, hi_v, cur_v, ld_v, up_v, dn_v;
  logic              up_wrap, dn_wrap;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign digit_ok[gi] = (bus.load_val[gi*4 +: 4] <= 4'd9);
  end

  always_comb begin
    eff_mode = (bus.mode == 2'b11) ? MODE_ALL : bus.mode;
    lo_v     = lo_of(eff_mode);
    hi_v     = hi_of(eff_mode);
    lo_bcd   = bin2bcd(lo_v);
    cur_v    = bcd2bin(count_q);
    ld_v     = bcd2bin(bus.load_val);
    load_ok  = (&digit_ok) && (ld_v >= MIN_VAL) && (ld_v <= MAX_VAL)
               && parity_ok(ld_v, eff_mode);

    // Nearest matching neighbour is at most two away; clamping covers a mode
    // change that leaves the count outside the new mode's [LO, HI].
    up_v = cur_v + 1;
    if (!parity_ok(up_v, eff_mode)) up_v = up_v + 1;
    if (up_v < lo_v) up_v = lo_v;
    up_wrap = (up_v > hi_v);
    if (up_wrap) up_v = lo_v;

    dn_v = cur_v - 1;
    if (!parity_ok(dn_v, eff_mode)) dn_v = dn_v - 1;
    if (dn_v > hi_v) dn_v = hi_v;
    dn_wrap = (dn_v < lo_v);
    if (dn_wrap) dn_v = hi_v;

    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        count_d = bus.load_val;
      end else begin
        count_d = lo_bcd;
        err_d   = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        count_d = bin2bcd(up_v);
        wrap_d  = up_wrap;
      end else begin
        count_d = bin2bcd(dn_v);
        wrap_d  = dn_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= lo_bcd;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_bcd_parity_range_counter.sv
// Directed vector bench for the BCD range counter: defaults table plus
// two-digit and single-valid-value sequences.
module tb_bcd_parity_range_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;

  bcd_parity_range_counter_if #(.DIGITS(1)) if0 ();
  bcd_parity_range_counter_if #(.DIGITS(2)) if1 ();
  bcd_parity_range_counter_if #(.DIGITS(1)) if2 ();

  bcd_parity_range_counter #(.DIGITS(1), .MIN_VAL(4), .MAX_VAL(9)) u0 (
    .clk(clk), .reset(rst0), .bus(if0.slave));
  bcd_parity_range_counter #(.DIGITS(2), .MIN_VAL(3), .MAX_VAL(21)) u1 (
    .clk(clk), .reset(rst1), .bus(if1.slave));
  bcd_parity_range_counter #(.DIGITS(1), .MIN_VAL(4), .MAX_VAL(5)) u2 (
    .clk(clk), .reset(rst2), .bus(if2.slave));

  typedef struct {
    bit         rst;
    bit         ld;
    bit         en;
    bit         up;
    logic [1:0] mode;
    logic [7:0] lv;
    logic [7:0] ec;
    bit         ew;
    bit         ee;
    string      nm;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input bit rst, input bit ld, input bit en, input bit up,
                     input logic [1:0] mode, input logic [7:0] lv,
                     input logic [7:0] ec, input bit ew, input bit ee, input string nm);
    vec_t v;
    v.rst = rst; v.ld = ld; v.en = en; v.up = up; v.mode = mode;
    v.lv = lv; v.ec = ec; v.ew = ew; v.ee = ee; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic report(input int inst, input vec_t v, input logic [7:0] c,
                        input logic w, input logic e);
    $display("u%0d %-14s rst=%0b ld=%0b en=%0b up=%0b mode=%0d lv=%h -> count=%h wrap=%0b err=%0b",
             inst, v.nm, v.rst, v.ld, v.en, v.up, v.mode, v.lv, c, w, e);
    check({v.nm, ".count"}, c, v.ec);
    check({v.nm, ".wrap"}, {7'd0, w}, {7'd0, v.ew});
    check({v.nm, ".err"}, {7'd0, e}, {7'd0, v.ee});
  endtask

  task automatic cyc1(input vec_t v);
    rst1 = v.rst; if1.load = v.ld; if1.en = v.en; if1.up = v.up;
    if1.mode = v.mode; if1.load_val = v.lv;
    @(posedge clk); #1;
    report(1, v, if1.count, if1.wrap, if1.err);
  endtask

  task automatic cyc2(input vec_t v);
    rst2 = v.rst; if2.load = v.ld; if2.en = v.en; if2.up = v.up;
    if2.mode = v.mode; if2.load_val = v.lv[3:0];
    @(posedge clk); #1;
    report(2, v, {4'd0, if2.count}, if2.wrap, if2.err);
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    if0.en = 0; if0.up = 0; if0.mode = 0; if0.load = 0; if0.load_val = 0;
    if1.en = 0; if1.up = 0; if1.mode = 0; if1.load = 0; if1.load_val = 0;
    if2.en = 0; if2.up = 0; if2.mode = 0; if2.load = 0; if2.load_val = 0;

    //  rst ld en up mode lv     count  w  e
    add(1, 0, 0, 1, 2'd1, 8'h0, 8'h5, 0, 0, "rst_odd");
    add(0, 0, 1, 1, 2'd1, 8'h0, 8'h7, 0, 0, "odd_up_7");
    add(0, 0, 1, 1, 2'd1, 8'h0, 8'h9, 0, 0, "odd_up_9");
    add(0, 0, 1, 1, 2'd1, 8'h0, 8'h5, 1, 0, "odd_wrap_5");
    add(0, 0, 1, 1, 2'd1, 8'h0, 8'h7, 0, 0, "odd_up_7b");
    add(0, 0, 1, 0, 2'd2, 8'h0, 8'h6, 0, 0, "even_dn_6");
    add(0, 0, 1, 0, 2'd2, 8'h0, 8'h4, 0, 0, "even_dn_4");
    add(0, 0, 1, 0, 2'd2, 8'h0, 8'h8, 1, 0, "even_wrap_8");
    add(0, 0, 1, 0, 2'd2, 8'h0, 8'h6, 0, 0, "even_dn_6b");
    add(0, 0, 0, 0, 2'd2, 8'h0, 8'h6, 0, 0, "hold");
    add(1, 0, 0, 1, 2'd0, 8'h0, 8'h4, 0, 0, "rst_all");
    add(0, 0, 1, 1, 2'd0, 8'h0, 8'h5, 0, 0, "all_up_5");
    add(0, 0, 1, 1, 2'd0, 8'h0, 8'h6, 0, 0, "all_up_6");
    add(0, 0, 1, 1, 2'd0, 8'h0, 8'h7, 0, 0, "all_up_7");
    add(0, 0, 1, 1, 2'd0, 8'h0, 8'h8, 0, 0, "all_up_8");
    add(0, 0, 1, 1, 2'd0, 8'h0, 8'h9, 0, 0, "all_up_9");
    add(0, 0, 1, 1, 2'd0, 8'h0, 8'h4, 1, 0, "all_wrap_4");
    add(0, 1, 0, 1, 2'd1, 8'h7, 8'h7, 0, 0, "load_7");
    add(0, 1, 0, 1, 2'd1, 8'h6, 8'h5, 0, 1, "load_6_bad");
    add(0, 0, 0, 1, 2'd1, 8'h0, 8'h5, 0, 0, "err_clears");
    add(0, 1, 0, 1, 2'd1, 8'hB, 8'h5, 0, 1, "load_B_bad");
    add(0, 1, 0, 1, 2'd0, 8'h3, 8'h4, 0, 1, "load_3_range");
    add(0, 1, 0, 1, 2'd2, 8'h9, 8'h4, 0, 1, "load_9_even");
    add(0, 1, 0, 1, 2'd0, 8'h6, 8'h6, 0, 0, "load_6_all");
    add(0, 0, 0, 1, 2'd1, 8'h0, 8'h6, 0, 0, "modesw_noen");
    add(0, 0, 1, 1, 2'd1, 8'h0, 8'h7, 0, 0, "modesw_up");
    add(1, 1, 1, 1, 2'd1, 8'h9, 8'h5, 0, 0, "prio_reset");
    add(0, 1, 1, 1, 2'd2, 8'h8, 8'h8, 0, 0, "prio_load");
    add(0, 0, 1, 1, 2'd3, 8'h0, 8'h9, 0, 0, "mode3_up_9");
    add(0, 0, 1, 1, 2'd3, 8'h0, 8'h4, 1, 0, "mode3_wrap");
    add(0, 0, 1, 0, 2'd1, 8'h0, 8'h9, 1, 0, "odd_dn_wrap");
    add(0, 0, 1, 0, 2'd1, 8'h0, 8'h7, 0, 0, "odd_dn_7");

    @(negedge clk);
    foreach (vecs[i]) begin
      rst0 = vecs[i].rst; if0.load = vecs[i].ld; if0.en = vecs[i].en;
      if0.up = vecs[i].up; if0.mode = vecs[i].mode; if0.load_val = vecs[i].lv[3:0];
      @(posedge clk); #1;
      report(0, vecs[i], {4'd0, if0.count}, if0.wrap, if0.err);
    end
    rst0 = 0; if0.en = 0; if0.load = 0;

    // Two digits, range 3..21: BCD carry/borrow across digits and wrap at both ends.
    vecs.delete();
    add(1, 0, 0, 1, 2'd1, 8'h00, 8'h03, 0, 0, "d2_rst_odd");
    add(0, 1, 0, 1, 2'd1, 8'h17, 8'h17, 0, 0, "d2_load_17");
    add(0, 0, 1, 1, 2'd1, 8'h00, 8'h19, 0, 0, "d2_up_19");
    add(0, 0, 1, 1, 2'd1, 8'h00, 8'h21, 0, 0, "d2_carry_21");
    add(0, 0, 1, 1, 2'd1, 8'h00, 8'h03, 1, 0, "d2_wrap_03");
    add(0, 0, 1, 0, 2'd1, 8'h00, 8'h21, 1, 0, "d2_dnwrap_21");
    add(0, 0, 1, 0, 2'd1, 8'h00, 8'h19, 0, 0, "d2_borrow_19");
    add(1, 0, 0, 1, 2'd2, 8'h00, 8'h04, 0, 0, "d2_rst_even");
    add(0, 1, 0, 1, 2'd2, 8'h1A, 8'h04, 0, 1, "d2_load_1A");
    add(0, 1, 0, 1, 2'd0, 8'h22, 8'h03, 0, 1, "d2_load_22");
    add(0, 1, 0, 1, 2'd0, 8'h20, 8'h20, 0, 0, "d2_load_20");
    add(0, 0, 1, 1, 2'd0, 8'h00, 8'h21, 0, 0, "d2_all_21");
    foreach (vecs[i]) cyc1(vecs[i]);
    rst1 = 0; if1.en = 0; if1.load = 0;

    // Range 4..5: odd mode has the single valid value 5, even mode only 4.
    vecs.delete();
    add(1, 0, 0, 1, 2'd1, 8'h0, 8'h5, 0, 0, "s_rst_odd");
    add(0, 0, 1, 1, 2'd1, 8'h0, 8'h5, 1, 0, "s_up_wrap");
    add(0, 0, 1, 1, 2'd1, 8'h0, 8'h5, 1, 0, "s_up_wrap2");
    add(0, 0, 1, 0, 2'd1, 8'h0, 8'h5, 1, 0, "s_dn_wrap");
    add(1, 0, 0, 1, 2'd2, 8'h0, 8'h4, 0, 0, "s_rst_even");
    add(0, 0, 1, 1, 2'd2, 8'h0, 8'h4, 1, 0, "s_even_wrap");
    add(0, 0, 1, 1, 2'd0, 8'h0, 8'h5, 0, 0, "s_all_up");
    foreach (vecs[i]) cyc2(vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
